readout_frame_sequencer: RTL and testbench

Sequences one ISFET chip acquisition run and turns the raw ADC mux stream into 256-bit FIFO words. On start it resets the chip, waits for calibration, and captures one 10-bit sample per `mux_update` pulse. It packs 16 samples per word, frames the word stream, and reports overflow and frame boundaries. It sits between the chip interface and the readout FIFO, on the system clock domain; `mux_update` and `adc_data` arrive already synchronised.

---
 rtl/readout_frame_sequencer_pkg.sv | 8 +
 rtl/readout_frame_sequencer_if.sv | 16 +
 rtl/readout_frame_sequencer_packer.sv | 32 +++
 rtl/readout_frame_sequencer.sv | 103 ++++++++++
 tb/tb_readout_frame_sequencer.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/readout_frame_sequencer_pkg.sv
// readout_frame_sequencer_pkg: shared types and constants for the readout sequencer
package readout_pkg;
  localparam int LANE_W = 16;
  localparam int ADC_W = 10;
  localparam int SAMPLES_PER_WORD = 16;
  typedef logic [255:0] word_t;
  typedef enum logic [2:0] {IDLE, CHIP_RST, WAIT_CALI, CAPTURE, ERROR} seq_state_t;
endpackage

// File: rtl/readout_frame_sequencer_if.sv
// readout_frame_sequencer_if: chip-side and FIFO-side signals of the sequencer
interface readout_frame_sequencer_if;
  import readout_pkg::*;
  logic chip_nrst;
  logic cali_done;
  logic mux_update;
  logic [ADC_W-1:0] adc_data;
  logic fifo_wr_en;
  word_t fifo_din;
  logic fifo_full;
  logic end_of_frame;
  modport master (output chip_nrst, fifo_wr_en, fifo_din, end_of_frame,
                  input cali_done, mux_update, adc_data, fifo_full);
  modport slave (input chip_nrst, fifo_wr_en, fifo_din, end_of_frame,
                 output cali_done, mux_update, adc_data, fifo_full);
endinterface

// File: rtl/readout_frame_sequencer_packer.sv
// sample_packer: packs zero-extended ADC samples into 16-lane words
module sample_packer
  import readout_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic [ADC_W-1:0] adc_data,
  output word_t            word,
  output logic             word_done
);
  localparam int CW = $clog2(SAMPLES_PER_WORD);
  logic [CW-1:0] cnt_q;
  word_t lanes_q;
  assign word_done = load && cnt_q == CW'(SAMPLES_PER_WORD - 1);
  // word already includes the sample arriving this cycle so the top can register it directly
  for (genvar k = 0; k < SAMPLES_PER_WORD; k++) begin : g_lane
    assign word[LANE_W*k +: LANE_W] = (load && cnt_q == CW'(k)) ? LANE_W'(adc_data)
                                                                  : lanes_q[LANE_W*k +: LANE_W];
  end
  // lane storage and sample counter; clear discards any partial word
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q <= '0;
      lanes_q <= '0;
    end else if (load) begin
      cnt_q <= word_done ? '0 : cnt_q + CW'(1);
      lanes_q <= word;
    end
  end
endmodule

// File: rtl/readout_frame_sequencer.sv
// readout_frame_sequencer: chip reset/calibration sequencing and framed FIFO word output
module readout_frame_sequencer
  import readout_pkg::*;
#(
  parameter int WORDS_PER_FRAME = 656,
  parameter int RST_CYCLES = 16,
  parameter int CALI_TIMEOUT = 1 << 20
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        sys_start_i,
  input  logic        stop_req_i,
  input  logic [15:0] num_frames_i,
  output logic        sys_rdy_o,
  output logic [15:0] frame_cnt_o,
  output logic        overflow_o,
  output logic        cali_err_o,
  readout_frame_sequencer_if.master bus
);
  localparam logic [2:0] ST_IDLE = IDLE;
  localparam logic [2:0] ST_CHIP_RST = CHIP_RST;
  localparam logic [2:0] ST_WAIT_CALI = WAIT_CALI;
  localparam logic [2:0] ST_CAPTURE = CAPTURE;
  localparam logic [2:0] ST_ERROR = ERROR;
  localparam int TW = $clog2((CALI_TIMEOUT > RST_CYCLES ? CALI_TIMEOUT : RST_CYCLES) + 1);
  localparam int WW = $clog2(WORDS_PER_FRAME + 1);
  logic [2:0] state_q, state_d;
  logic start_q, stop_q, overflow_q, cali_err_q, wr_en_q, eof_q;
  logic [TW-1:0] tmr_q;
  logic [WW-1:0] word_q;
  logic [15:0] nframes_q, frame_cnt_q;
  word_t din_q, word;
  logic word_done, capture, start_edge, restart, frame_end, run_done;
  assign capture = state_q == ST_CAPTURE;
  assign start_edge = sys_start_i && !start_q;
  assign restart = start_edge && (state_q == ST_IDLE || state_q == ST_ERROR);
  assign frame_end = word_done && word_q == WW'(WORDS_PER_FRAME - 1);
  assign run_done = frame_end && ((nframes_q != 16'd0 && {1'b0, frame_cnt_q} + 17'd1 == {1'b0, nframes_q})
                                  || stop_q || stop_req_i);
  sample_packer u_packer (
    .clk(sys_clk), .rst(sys_rst), .load(capture && bus.mux_update), .clear(!capture),
    .adc_data(bus.adc_data), .word(word), .word_done(word_done)
  );
  // run-level state transitions
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_ERROR: state_d = start_edge ? ST_CHIP_RST : state_q;
      ST_CHIP_RST: state_d = tmr_q == TW'(RST_CYCLES - 1) ? ST_WAIT_CALI : state_q;
      ST_WAIT_CALI: state_d = bus.cali_done ? ST_CAPTURE
                            : tmr_q == TW'(CALI_TIMEOUT - 1) ? ST_ERROR : state_q;
      ST_CAPTURE: state_d = run_done ? ST_IDLE : state_q;
      default: state_d = ST_IDLE;
    endcase
  end
  // state, timers, frame/word counters, sticky flags and the registered FIFO port
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
      start_q <= 1'b0;
      stop_q <= 1'b0;
      tmr_q <= '0;
      word_q <= '0;
      nframes_q <= '0;
      frame_cnt_q <= '0;
      overflow_q <= 1'b0;
      cali_err_q <= 1'b0;
      wr_en_q <= 1'b0;
      eof_q <= 1'b0;
      din_q <= '0;
    end else begin
      state_q <= state_d;
      start_q <= sys_start_i;
      tmr_q <= (state_d != state_q) ? '0 : tmr_q + TW'(1);
      wr_en_q <= word_done && !bus.fifo_full;
      eof_q <= frame_end;
      if (word_done && !bus.fifo_full) din_q <= word;
      if (word_done && bus.fifo_full) overflow_q <= 1'b1;
      if (word_done) word_q <= frame_end ? '0 : word_q + WW'(1);
      if (frame_end && frame_cnt_q != 16'hFFFF) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (capture && stop_req_i) stop_q <= 1'b1;
      if (state_q == ST_WAIT_CALI && state_d == ST_ERROR) cali_err_q <= 1'b1;
      if (restart) begin
        stop_q <= 1'b0;
        cali_err_q <= 1'b0;
        word_q <= '0;
      end
      if (restart && state_q == ST_IDLE) begin
        nframes_q <= num_frames_i;
        frame_cnt_q <= '0;
        overflow_q <= 1'b0;
      end
    end
  end
  assign sys_rdy_o = state_q == ST_IDLE;
  assign frame_cnt_o = frame_cnt_q;
  assign overflow_o = overflow_q;
  assign cali_err_o = cali_err_q;
  assign bus.chip_nrst = state_q == ST_WAIT_CALI || state_q == ST_CAPTURE;
  assign bus.fifo_wr_en = wr_en_q;
  assign bus.fifo_din = din_q;
  assign bus.end_of_frame = eof_q;
endmodule

// File: tb/tb_readout_frame_sequencer.sv
// tb_readout_frame_sequencer: randomized scoreboard bench for the readout sequencer
module tb_readout_frame_sequencer;
  import readout_pkg::*;
  localparam int WPF = 4;
  localparam int TO = 64;
  logic clk = 1'b0, rst = 1'b1, sys_start = 1'b0, stop_req = 1'b0;
  logic [15:0] num_frames = '0;
  logic sys_rdy, overflow, cali_err;
  logic [15:0] frame_cnt;
  readout_frame_sequencer_if bus();
  readout_frame_sequencer #(.WORDS_PER_FRAME(WPF), .RST_CYCLES(16), .CALI_TIMEOUT(TO)) dut (
    .sys_clk(clk), .sys_rst(rst), .sys_start_i(sys_start), .stop_req_i(stop_req),
    .num_frames_i(num_frames), .sys_rdy_o(sys_rdy), .frame_cnt_o(frame_cnt),
    .overflow_o(overflow), .cali_err_o(cali_err), .bus(bus)
  );
  always #5 clk = ~clk;
  typedef struct { logic wr; word_t din; logic eof; } exp_t;
  exp_t exp_q[$];
  int n_vec = 0, n_err = 0, n_wr = 0, cyc = 0, last_wr = -1;
  bit gap_on = 0, got_first = 0;
  word_t first_din;
  // reference model state: samples/words/frames of the current run
  bit m_cap = 0, m_stop = 0, m_ovf = 0;
  int m_n = 0, m_words = 0;
  logic [15:0] m_frames = '0, m_nf = '0;
  word_t m_word = '0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic model(input logic mu, input logic [9:0] ad, input logic fu, input logic sr);
    bit last;
    if (!m_cap) return;
    if (sr) m_stop = 1;
    if (mu) begin
      m_word[16*m_n +: 16] = {6'b0, ad};
      m_n++;
      if (m_n == SAMPLES_PER_WORD) begin
        last = (m_words % WPF) == WPF - 1;
        if (!fu) exp_q.push_back('{1'b1, m_word, last});
        else begin
          m_ovf = 1;
          if (last) exp_q.push_back('{1'b0, '0, 1'b1});
        end
        m_n = 0;
        m_words++;
        if (last) begin
          if (m_frames != 16'hFFFF) m_frames++;
          if ((m_nf != 0 && m_frames == m_nf) || m_stop) m_cap = 0;
        end
      end
    end
  endtask

  task automatic drive(input logic mu, input logic [9:0] ad, input logic fu = 1'b0,
                       input logic sr = 1'b0, input logic st = 1'b0);
    @(negedge clk);
    bus.mux_update = mu;
    bus.adc_data = ad;
    bus.fifo_full = fu;
    stop_req = sr;
    sys_start = st;
    model(mu, ad, fu, sr);
  endtask

  task automatic start_run(input logic [15:0] nf, input bit fresh, input bit do_cali);
    int lows = 0;
    bus.cali_done = 1'b0;
    num_frames = nf;
    if (fresh) begin
      m_nf = nf;
      m_frames = 0;
      m_ovf = 0;
    end
    m_stop = 0; m_n = 0; m_words = 0; m_cap = 0;
    drive(1'($urandom), 10'($urandom), 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      drive(1'($urandom), 10'($urandom));
      if (!bus.chip_nrst) lows++;
    end
    chk("nrst_low_cycles", lows, 16);
    drive(1'($urandom), 10'($urandom));
    chk("nrst_release", bus.chip_nrst, 1'b1);
    if (!do_cali) return;
    repeat ($urandom_range(0, 5)) drive(1'($urandom), 10'($urandom));
    drive(1'($urandom), 10'($urandom));
    bus.cali_done = 1'b1;
    m_cap = 1;
  endtask

  task automatic run_capture(input int mode, input int full_word, input int stop_word, input int stop_n);
    int g = 0, idx = 0;
    bit stopped = 0;
    logic mu, fu, sr;
    logic [9:0] ad;
    while (m_cap && g < 20000) begin
      mu = (mode == 2) ? 1'b1 : ($urandom_range(0, 3) != 0);
      ad = (mode == 1) ? 10'(idx) : 10'($urandom);
      fu = m_words == full_word;
      sr = !stopped && mu && m_words == stop_word && m_n == stop_n;
      if (sr) stopped = 1;
      drive(mu, ad, fu, sr);
      g++;
      if (mu) idx++;
    end
    if (g >= 20000) chk("run_cycle_budget", g, 0);
    repeat (2) drive(1'($urandom), 10'($urandom));
    chk("end_rdy", sys_rdy, 1'b1);
    chk("end_frame_cnt", frame_cnt, m_frames);
    chk("end_overflow", overflow, m_ovf);
    chk("end_pending", exp_q.size(), 0);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // monitor: every write or frame marker must match the next scoreboard entry
  always @(negedge clk) begin
    exp_t e;
    if (bus.fifo_wr_en || bus.end_of_frame) begin
      if (exp_q.size() == 0) chk("unexpected_event", {bus.fifo_wr_en, bus.end_of_frame}, 0);
      else begin
        e = exp_q.pop_front();
        chk("wr_en", bus.fifo_wr_en, e.wr);
        chk("eof", bus.end_of_frame, e.eof);
        if (e.wr) chk("din", bus.fifo_din, e.din);
      end
      if (bus.fifo_wr_en) begin
        n_wr++;
        if (!got_first) begin
          first_din = bus.fifo_din;
          got_first = 1;
        end
        if (gap_on && last_wr >= 0) chk("wr_gap", cyc - last_wr, 16);
        last_wr = cyc;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    word_t w0;
    bus.cali_done = 1'b0; bus.mux_update = 1'b0; bus.adc_data = '0; bus.fifo_full = 1'b0;
    for (int k = 0; k < 16; k++) w0[16*k +: 16] = 16'(k);
    repeat (3) @(negedge clk);
    chk("rst_rdy", sys_rdy, 1'b1);
    chk("rst_nrst", bus.chip_nrst, 1'b0);
    chk("rst_wr_en", bus.fifo_wr_en, 1'b0);
    chk("rst_eof", bus.end_of_frame, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_cali_err", cali_err, 1'b0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_din", bus.fifo_din, 0);
    rst = 1'b0;
    // nominal two-frame run with index data
    n_wr = 0; got_first = 0;
    start_run(2, 1, 1);
    run_capture(1, -1, -1, -1);
    chk("nom_writes", n_wr, 8);
    chk("nom_frames", frame_cnt, 2);
    chk("nom_word0", first_din, w0);
    // FIFO full during the second word of frame 0
    n_wr = 0;
    start_run(2, 1, 1);
    run_capture(0, 1, -1, -1);
    chk("ovf_writes", n_wr, 7);
    chk("ovf_flag", overflow, 1'b1);
    // continuous mode, stop mid frame 1
    n_wr = 0;
    start_run(0, 1, 1);
    run_capture(0, -1, 5, 3);
    chk("stop_writes", n_wr, 8);
    chk("stop_frames", frame_cnt, 2);
    // stop together with the last sample of frame 0
    n_wr = 0;
    start_run(0, 1, 1);
    run_capture(0, -1, 3, 15);
    chk("stop_last_writes", n_wr, 4);
    chk("stop_last_frames", frame_cnt, 1);
    // back-to-back samples
    n_wr = 0; gap_on = 1; last_wr = -1;
    start_run(2, 1, 1);
    run_capture(2, -1, -1, -1);
    gap_on = 0;
    chk("thru_writes", n_wr, 8);
    // calibration timeout, then restart from ERROR
    start_run(1, 1, 0);
    repeat (TO - 1) drive(1'($urandom), 10'($urandom));
    chk("cali_err_early", cali_err, 1'b0);
    drive(1'($urandom), 10'($urandom));
    chk("cali_err_set", cali_err, 1'b1);
    chk("err_rdy", sys_rdy, 1'b0);
    chk("err_nrst", bus.chip_nrst, 1'b0);
    n_wr = 0;
    start_run(1, 0, 1);
    chk("cali_err_cleared", cali_err, 1'b0);
    run_capture(0, -1, -1, -1);
    chk("restart_writes", n_wr, 4);
    // reset after 7 samples of a word
    start_run(1, 1, 1);
    repeat (7) drive(1'b1, 10'($urandom));
    drive(1'b0, 10'd0);
    rst = 1'b1;
    m_cap = 0;
    drive(1'b0, 10'd0);
    chk("mid_rst_rdy", sys_rdy, 1'b1);
    chk("mid_rst_nrst", bus.chip_nrst, 1'b0);
    chk("mid_rst_wr_en", bus.fifo_wr_en, 1'b0);
    chk("mid_rst_overflow", overflow, 1'b0);
    chk("mid_rst_frame_cnt", frame_cnt, 0);
    chk("mid_rst_din", bus.fifo_din, 0);
    rst = 1'b0;
    n_wr = 0;
    start_run(1, 1, 1);
    run_capture(1, -1, -1, -1);
    chk("post_rst_writes", n_wr, 4);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
